// File: rtl/audio2fifo.sv
// audio2fifo: captures the left-channel I2S ADC word from a codec that
// drives bclk/adclrc, and pushes one word per LR frame into the write port
// of a dual-clock FIFO clocked by bclk.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | disarmed; waits for start2fill=1 with an empty FIFO
// ST_WAIT    | armed; waits for adclrc falling (left-channel frame start)
// ST_SHIFT   | shifting DATA_W left-channel bits, MSB first
// ST_WRITE   | one cycle while wrreq (if any) is presented to the FIFO
// ST_DONE    | FIFO reported full; parked until start2fill drops
module audio2fifo #(
  parameter int DATA_W = 16
) (
  input  logic              bclk,
  input  logic              reset,
  input  logic              start2fill,
  input  logic              adcdata,
  input  logic              adclrc,
  input  logic              wrempty,
  input  logic              wrfull,
  output logic [DATA_W-1:0] audiodata,
  output logic              wrclk,
  output logic              wrreq
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SHIFT,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              lrc_q;
  logic              frame_start;

  // The FIFO write port runs directly on the codec bit clock.
  assign wrclk = bclk;

  // adclrc low now but high on the previous edge: this edge is the I2S delay slot.
  assign frame_start = ~adclrc & lrc_q;

  // Next shift value; also the complete word on the last bit of a frame.
  assign shift_d = {shift_q[DATA_W-2:0], adcdata};

  // Frame sequencing, deserialiser and registered FIFO write interface.
  always_ff @(posedge bclk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      lrc_q     <= 1'b1;
      audiodata <= '0;
      wrreq     <= 1'b0;
    end else begin
      lrc_q <= adclrc;
      wrreq <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start2fill && wrempty) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!start2fill) begin
            state_q <= ST_IDLE;
          end else if (frame_start) begin
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_q <= shift_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_q <= ST_WRITE;
            // Word and request are registered together so the FIFO sees
            // stable data on the edge that ends the WRITE cycle.
            if (start2fill && !wrfull) begin
              audiodata <= shift_d;
              wrreq     <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (wrfull)           state_q <= ST_DONE;
          else if (!start2fill) state_q <= ST_IDLE;
          else                  state_q <= ST_WAIT;
        end
        ST_DONE: begin
          if (!start2fill) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio2fifo.sv
// Bench for audio2fifo: drives I2S frames, predicts FIFO writes from frame
// timing and the captured bit history, compares every bclk cycle.
module tb_audio2fifo;

  logic        bclk = 1'b0;
  logic        reset = 1'b0;
  logic        start2fill = 1'b0;
  logic        adcdata = 1'b0;
  logic        adclrc = 1'b1;
  logic        wrempty = 1'b1;
  logic        wrfull = 1'b0;
  logic [15:0] audiodata;
  logic        wrclk;
  logic        wrreq;

  int checks = 0;
  int failures = 0;

  audio2fifo #(.DATA_W(16)) dut (
    .bclk      (bclk),
    .reset     (reset),
    .start2fill(start2fill),
    .adcdata   (adcdata),
    .adclrc    (adclrc),
    .wrempty   (wrempty),
    .wrfull    (wrfull),
    .audiodata (audiodata),
    .wrclk     (wrclk),
    .wrreq     (wrreq)
  );

  initial forever #5 bclk = ~bclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Capture activity in frame terms: off, armed, collecting the 16 bits
  // after a frame start, the write slot, or parked after a full FIFO.
  typedef enum int {M_OFF, M_ARMED, M_BUSY, M_POST, M_PARKED} mode_t;
  mode_t       mode = M_OFF;
  logic        exp_wrreq = 1'b0;
  logic [15:0] exp_data = 16'h0000;
  bit          lrc_prev = 1'b1;
  bit          bitq[$];
  int          age = 0;

  function automatic logic [15:0] word_of(input bit q[$]);
    int v = 0;
    for (int i = 0; i < q.size(); i++) v = v * 2 + int'(q[i]);
    return v[15:0];
  endfunction

  initial forever begin
    @(posedge bclk or negedge reset);
    if (!reset) begin
      mode = M_OFF; exp_wrreq = 1'b0; exp_data = 16'h0000;
      lrc_prev = 1'b1; bitq.delete(); age = 0;
    end else begin
      bitq.push_back(bit'(adcdata));
      if (bitq.size() > 16) void'(bitq.pop_front());
      exp_wrreq = 1'b0;
      case (mode)
        M_OFF:    if (start2fill && wrempty) mode = M_ARMED;
        M_ARMED: begin
          if (!start2fill) mode = M_OFF;
          else if (!adclrc && lrc_prev) begin mode = M_BUSY; age = 0; end
        end
        M_BUSY: begin
          age++;
          if (age == 16) begin
            if (start2fill && !wrfull) begin
              exp_wrreq = 1'b1;
              exp_data  = word_of(bitq);
            end
            mode = M_POST;
          end
        end
        M_POST: begin
          if (wrfull) mode = M_PARKED;
          else if (!start2fill) mode = M_OFF;
          else mode = M_ARMED;
        end
        M_PARKED: if (!start2fill) mode = M_OFF;
        default:  mode = M_OFF;
      endcase
      lrc_prev = bit'(adclrc);
    end
  end

  // Compare on the falling edge, half a cycle away from DUT updates.
  initial forever begin
    @(negedge bclk);
    chk("wrreq", {31'd0, wrreq}, {31'd0, exp_wrreq});
    chk("audiodata", {16'd0, audiodata}, {16'd0, exp_data});
    chk("wrclk_low", {31'd0, wrclk}, 32'd0);
  end

  initial forever begin
    @(posedge bclk);
    #1;
    chk("wrclk_high", {31'd0, wrclk}, 32'd1);
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge bclk);
      adclrc  = 1'b1;
      adcdata = 1'($urandom_range(1, 0));
    end
  endtask

  // One 64-bclk LR frame, left word MSB-first after the delay slot.
  // rst_at: cycle index at which reset pulses for two cycles (-1 none).
  // ctrl_k: cycle index at which the control inputs take new values (-1 none).
  task automatic frame(input logic [15:0] lw, input int rst_at, input int ctrl_k,
                       input logic s2f_n, input logic full_n, input logic empty_n,
                       output int pulse_k);
    logic [15:0] w;
    w = lw;
    pulse_k = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge bclk);
      if (wrreq === 1'b1 && pulse_k < 0 && k > 0) pulse_k = k;
      adclrc  = (k >= 32);
      adcdata = (k >= 1 && k <= 16) ? w[16 - k] : 1'($urandom_range(1, 0));
      if (k == ctrl_k) begin
        start2fill = s2f_n; wrfull = full_n; wrempty = empty_n;
      end
      if (rst_at >= 0 && k == rst_at + 2) reset = 1'b1;
      if (k == rst_at) begin #1 reset = 1'b0; end
    end
  endtask

  task automatic plain(input logic [15:0] lw, output int pk);
    frame(lw, -1, -1, 1'b0, 1'b0, 1'b0, pk);
  endtask

  initial begin
    int pk;
    // Reset
    repeat (3) @(negedge bclk);
    chk("rst_audiodata", {16'd0, audiodata}, 32'h0000);
    chk("rst_wrreq", {31'd0, wrreq}, 32'd0);
    @(negedge bclk);
    #1 reset = 1'b1;

    // Disabled
    start2fill = 1'b0;
    for (int f = 0; f < 3; f++) begin
      plain(16'($urandom), pk);
      chk("disabled_pulse", pk, -1);
    end
    chk("disabled_data", {16'd0, audiodata}, 32'h0000);

    // Basic capture
    start2fill = 1'b1; wrempty = 1'b1;
    idle(4);
    plain(16'h800B, pk);
    chk("basic_pulse_k", pk, 17);
    chk("basic_data", {16'd0, audiodata}, 32'h800B);

    // Full: drop the word, park, ignore later frames
    wrfull = 1'b1; wrempty = 1'b0;
    idle(4);
    plain(16'h1111, pk);
    chk("full_pulse", pk, -1);
    plain(16'h7777, pk);
    chk("parked_pulse", pk, -1);
    chk("full_data_held", {16'd0, audiodata}, 32'h800B);
    start2fill = 1'b0; wrfull = 1'b0;
    idle(4);
    start2fill = 1'b1;
    idle(4);
    plain(16'h2222, pk);
    chk("not_empty_pulse", pk, -1);
    wrempty = 1'b1;
    idle(4);
    plain(16'h3C3C, pk);
    chk("rearm_pulse_k", pk, 17);
    chk("rearm_data", {16'd0, audiodata}, 32'h3C3C);

    // Streaming, back-to-back frames
    plain(16'h1234, pk);
    chk("stream0_pulse_k", pk, 17);
    chk("stream0_data", {16'd0, audiodata}, 32'h1234);
    plain(16'hFFFF, pk);
    chk("stream1_pulse_k", pk, 17);
    chk("stream1_data", {16'd0, audiodata}, 32'hFFFF);
    plain(16'h0001, pk);
    chk("stream2_pulse_k", pk, 17);
    chk("stream2_data", {16'd0, audiodata}, 32'h0001);

    // Mid-frame reset after 8 bits
    frame(16'hBEEF, 9, -1, 1'b0, 1'b0, 1'b0, pk);
    chk("midrst_pulse", pk, -1);
    chk("midrst_data", {16'd0, audiodata}, 32'h0000);
    plain(16'hA5A5, pk);
    chk("after_rst_pulse_k", pk, 17);
    chk("after_rst_data", {16'd0, audiodata}, 32'hA5A5);

    // Randomised control changes; the reference model judges every cycle
    for (int f = 0; f < 24; f++) begin
      logic s2f_n, full_n, empty_n;
      s2f_n   = ($urandom_range(3, 0) != 0);
      full_n  = ($urandom_range(3, 0) == 0);
      empty_n = ($urandom_range(2, 0) != 0);
      frame(16'($urandom), -1, int'($urandom_range(63, 0)), s2f_n, full_n, empty_n, pk);
      if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(6, 1)));
    end

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio2fifo.md
Name: audio2fifo

Overview:
- Deserialises the left-channel 16-bit ADC sample from an I2S audio codec (codec is clock master: bclk, adclrc) and writes one word per frame into a dual-clock FIFO write port.
- Sits between the codec serial interface and the spectrum-analysis FIFO.
- The FIFO write clock is bclk.
- Filling is armed by start2fill and stops when the FIFO reports full.

Parameters:
- DATA_W, 16, sample width in bits (shift length and audiodata width).

Ports:
- bclk  input  1  codec bit clock; the single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start2fill  input  1  level enable; 1 = capture samples into the FIFO.
- adcdata  input  1  serial ADC data, MSB first, changes on bclk falling edge.
- adclrc  input  1  codec LR clock; 0 = left channel, 1 = right channel; changes on bclk falling edge.
- wrempty  input  1  FIFO write-side empty flag.
- wrfull  input  1  FIFO write-side full flag.
- audiodata  output  DATA_W  parallel sample to FIFO data input.
- wrclk  output  1  FIFO write clock; combinational copy of bclk.
- wrreq  output  1  FIFO write request, one bclk cycle per sample.

Behaviour:
- Reset (reset=0, async): state=IDLE, audiodata=0, wrreq=0, shift register=0, bit counter=0, lrc_d=1. wrclk keeps following bclk during reset.
- lrc_d is adclrc registered on each bclk rising edge. A frame start is adclrc=0 while lrc_d=1, sampled at a rising edge.
- State IDLE:
  - wrreq=0.
  - Go to WAIT_FRAME when start2fill=1 and wrempty=1.
  - If start2fill=1 and wrempty=0, stay in IDLE.
- State WAIT_FRAME:
  - On the frame-start rising edge (the I2S one-bit delay slot; adcdata is ignored), clear the counter and go to SHIFT.
  - If start2fill=0, go to IDLE.
- State SHIFT:
  - On each of the next DATA_W rising edges: shift = {shift[DATA_W-2:0], adcdata}; counter increments.
  - After the DATA_W-th bit, go to WRITE.
  - start2fill dropping here does not abort; it is evaluated in WRITE.
- State WRITE (one cycle):
  - audiodata is loaded with the shift register.
  - wrreq=1 for exactly this one bclk cycle, provided wrfull=0 and start2fill=1. Data is registered together with wrreq, so the FIFO captures the word on the next rising edge.
  - If wrfull=1: no wrreq, sample dropped, go to DONE.
  - If start2fill=0: no wrreq, go to IDLE.
  - Otherwise go to WAIT_FRAME.
- State DONE: wrreq=0. Wait for start2fill=0, then go to IDLE (re-arm requires a new start2fill rising level plus wrempty=1).
- Latency:
  - MSB captured on the 2nd rising edge after adclrc falls; LSB on the 17th.
  - wrreq is high during the cycle after the LSB capture.
- Right-channel data (adclrc=1) is never captured. Exactly one write per LR frame (48 kHz).
- wrfull asserting mid-SHIFT has no effect until WRITE.
- audiodata holds its last written value between writes.
- adclrc falling while already in SHIFT is ignored; the frame completes.
- Async reset mid-frame aborts the capture; after release, the next frame start is awaited. A partial frame is never written.

Test Plan:
- Reset: hold reset=0 -> audiodata=0x0000, wrreq=0, wrclk toggles with bclk.
- Basic capture: release reset, start2fill=1, wrempty=1, send left word 0x800B (bits 1000_0000_0000_1011) after adclrc falls -> one wrreq pulse of one bclk period on the cycle after the LSB, audiodata=0x800B. No wrreq during the right half.
- Disabled: start2fill=0 for several frames with data toggling -> wrreq stays 0, audiodata stays 0.
- Full: wrfull=1 before the WRITE slot -> no wrreq, block idles in DONE across later frames. Drop start2fill, then raise it with wrempty=1 -> capture resumes on the next frame.
- Streaming: three consecutive frames with 0x1234, 0xFFFF, 0x0001 -> three wrreq pulses exactly one frame apart, audiodata matching each word.
- Mid-frame reset: assert reset after 8 bits shifted -> wrreq never pulses for that frame. The next full frame (0xA5A5) is written correctly.
